// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : shared types and constants for the memory-unit arbiter
// Revision        : 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;

    localparam logic [1:0] MEM_FUNC_NOP = 2'b00;
    localparam logic [1:0] GET_CONTENTS = 2'b01;
    localparam logic [1:0] SET_CONTENTS = 2'b10;

    localparam int REQ_TRAVERSAL = 0;
    localparam int REQ_EXECUTE   = 1;
    localparam int REQ_CELL      = 2;
    localparam int REQ_INCR      = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin winner select with lock override
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_owner_i,
    input  logic               lock_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   winner_idx_o,
    output logic [NUM_REQ-1:0] winner_oh_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        winner_idx_o = last_owner_i;
        found        = 1'b0;
        cand         = '0;
        if (lock_i && req_i[last_owner_i]) begin
            found = 1'b1;
        end else begin
            // Search starts one past the previous owner so it gets lowest priority.
            for (int i = 1; i <= NUM_REQ; i++) begin
                cand = IDX_W'((int'(last_owner_i) + i) % NUM_REQ);
                if (!found && req_i[cand]) begin
                    found        = 1'b1;
                    winner_idx_o = cand;
                end
            end
        end
        valid_o     = found;
        winner_oh_o = found ? (NUM_REQ'(1) << winner_idx_o) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin arbiter sharing one memory unit among requesters
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_lock,
    input  logic [2*NUM_REQ-1:0]            req_func,
    input  logic [NUM_REQ*MEM_ADDR_W-1:0]   req_addr1,
    input  logic [NUM_REQ*MEM_ADDR_W-1:0]   req_addr2,
    input  logic [NUM_REQ*MEM_DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic                            err,
    output logic [MEM_DATA_W-1:0]           rdata1,
    output logic [MEM_DATA_W-1:0]           rdata2,
    output logic                            mem_execute,
    output logic [1:0]                      mem_func,
    output logic [MEM_ADDR_W-1:0]           address1,
    output logic [MEM_ADDR_W-1:0]           address2,
    output logic [MEM_DATA_W-1:0]           write_data,
    input  logic                            mem_ready,
    input  logic [MEM_DATA_W-1:0]           read_data1,
    input  logic [MEM_DATA_W-1:0]           read_data2
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       last_owner_q;
    logic [NUM_REQ-1:0]     gnt_q;
    logic                   lock_q;
    logic                   err_q;
    logic [1:0]             func_q;
    logic [MEM_ADDR_W-1:0]  addr1_q, addr2_q;
    logic [MEM_DATA_W-1:0]  wdata_q, rdata1_q, rdata2_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_REQ-1:0]     pick_oh;
    logic                   timeout_hit;

    logic [1:0]             func_a  [NUM_REQ];
    logic [MEM_ADDR_W-1:0]  addr1_a [NUM_REQ];
    logic [MEM_ADDR_W-1:0]  addr2_a [NUM_REQ];
    logic [MEM_DATA_W-1:0]  wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign func_a[g]  = req_func[2*g +: 2];
        assign addr1_a[g] = req_addr1[g*MEM_ADDR_W +: MEM_ADDR_W];
        assign addr2_a[g] = req_addr2[g*MEM_ADDR_W +: MEM_ADDR_W];
        assign wdata_a[g] = req_wdata[g*MEM_DATA_W +: MEM_DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .lock_i       (lock_q),
        .valid_o      (pick_valid),
        .winner_idx_o (pick_idx),
        .winner_oh_o  (pick_oh)
    );

    // The counter holds the number of WAIT cycles already spent.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_execute = 1'b0;
        mem_func    = MEM_FUNC_NOP;
        done        = '0;
        err         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_execute = 1'b1;
                mem_func    = func_q;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = gnt_q;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            gnt_q        <= '0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
            func_q       <= MEM_FUNC_NOP;
            addr1_q      <= '0;
            addr2_q      <= '0;
            wdata_q      <= '0;
            rdata1_q     <= '0;
            rdata2_q     <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= pick_oh;
                        lock_q  <= req_lock[pick_idx];
                        func_q  <= func_a[pick_idx];
                        addr1_q <= addr1_a[pick_idx];
                        addr2_q <= addr2_a[pick_idx];
                        wdata_q <= wdata_a[pick_idx];
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A response in the final cycle wins over the timeout.
                    if (mem_ready) begin
                        rdata1_q <= read_data1;
                        rdata2_q <= read_data2;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    last_owner_q <= pick_idx_of(gnt_q);
                    gnt_q        <= '0;
                    cnt_q        <= '0;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [IDX_W-1:0] pick_idx_of(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign gnt        = gnt_q;
    assign rdata1     = rdata1_q;
    assign rdata2     = rdata2_q;
    assign address1   = addr1_q;
    assign address2   = addr2_q;
    assign write_data = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int AW = MEM_ADDR_W;
    localparam int DW = MEM_DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     req_lock = '0;
    logic [2*NR-1:0]   req_func = '0;
    logic [NR*AW-1:0]  req_addr1 = '0;
    logic [NR*AW-1:0]  req_addr2 = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic              mem_ready = 1'b0;
    logic [DW-1:0]     read_data1 = '0;
    logic [DW-1:0]     read_data2 = '0;

    wire  [NR-1:0]     gnt, done;
    wire               err, mem_execute;
    wire  [DW-1:0]     rdata1, rdata2, write_data;
    wire  [1:0]        mem_func;
    wire  [AW-1:0]     address1, address2;

    int checks = 0;
    int errors = 0;
    int exec_cnt = 0;
    int onehot_bad = 0;

    mem_arbiter #(.NUM_REQ(NR), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_func(req_func),
        .req_addr1(req_addr1), .req_addr2(req_addr2), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .rdata1(rdata1), .rdata2(rdata2),
        .mem_execute(mem_execute), .mem_func(mem_func), .address1(address1),
        .address2(address2), .write_data(write_data), .mem_ready(mem_ready),
        .read_data1(read_data1), .read_data2(read_data2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_execute) exec_cnt <= exec_cnt + 1;
    always @(negedge clk) if (!$onehot0(gnt)) onehot_bad <= onehot_bad + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_fields(input int idx, input logic [1:0] f, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a2, input logic [DW-1:0] wd);
        req_func[idx*2 +: 2]   = f;
        req_addr1[idx*AW +: AW] = a1;
        req_addr2[idx*AW +: AW] = a2;
        req_wdata[idx*DW +: DW] = wd;
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0; req = '0; req_lock = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Entered at the falling edge of an IDLE cycle with the request already set.
    task automatic do_access(input int owner, input int lat, input logic [DW-1:0] rd1,
                             input logic [DW-1:0] rd2, input bit drop);
        logic [NR-1:0] exp_oh;
        exp_oh = 4'b0001 << owner;
        tick();
        checks++;
        if (gnt !== exp_oh || mem_execute !== 1'b1) begin
            errors++;
            $display("FAIL issue_grant: gnt=%b exec=%b, expected gnt=%b exec=1", gnt, mem_execute, exp_oh);
        end
        for (int k = 0; k < lat; k++) tick();
        mem_ready = 1'b1; read_data1 = rd1; read_data2 = rd2;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (done !== exp_oh || err !== 1'b0 || rdata1 !== rd1 || rdata2 !== rd2) begin
            errors++;
            $display("FAIL access_done: done=%b err=%b rdata1=%h rdata2=%h, expected done=%b err=0 rdata1=%h rdata2=%h",
                     done, err, rdata1, rdata2, exp_oh, rd1, rd2);
        end
        if (drop) req[owner] = 1'b0;
        tick();
        checks++;
        if (done !== '0 || gnt !== '0) begin
            errors++;
            $display("FAIL idle_after_done: done=%b gnt=%b, expected both 0", done, gnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (gnt !== '0 || done !== '0 || err !== 1'b0 || mem_execute !== 1'b0 || mem_func !== 2'b00 ||
            address1 !== '0 || address2 !== '0 || write_data !== '0 || rdata1 !== '0 || rdata2 !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b done=%b err=%b exec=%b func=%b a1=%h a2=%h wd=%h r1=%h r2=%h, expected all 0",
                     gnt, done, err, mem_execute, mem_func, address1, address2, write_data, rdata1, rdata2);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== '0 || mem_execute !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: gnt=%b exec=%b, expected 0 0", gnt, mem_execute);
        end
    endtask

    task automatic test_single();
        int e0;
        e0 = exec_cnt;
        set_fields(0, GET_CONTENTS, 16'd10, 16'd20, 32'h0);
        req = 4'b0001;
        tick();
        checks++;
        if (mem_execute !== 1'b1 || address1 !== 16'd10 || mem_func !== GET_CONTENTS || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL single_issue: exec=%b a1=%0d func=%b gnt=%b, expected 1 10 01 0001",
                     mem_execute, address1, mem_func, gnt);
        end
        tick();
        checks++;
        if (mem_execute !== 1'b0 || mem_func !== 2'b00 || address1 !== 16'd10) begin
            errors++;
            $display("FAIL single_wait: exec=%b func=%b a1=%0d, expected 0 00 10", mem_execute, mem_func, address1);
        end
        tick();
        mem_ready = 1'b1; read_data1 = 32'hDEAD_BEEF; read_data2 = 32'h0BAD_F00D;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (done !== 4'b0001 || rdata1 !== 32'hDEAD_BEEF || err !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b rdata1=%h err=%b, expected 0001 deadbeef 0", done, rdata1, err);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || done !== 4'b0000 || exec_cnt - e0 != 1) begin
            errors++;
            $display("FAIL single_after: gnt=%b done=%b exec_pulses=%0d, expected 0000 0000 1", gnt, done, exec_cnt - e0);
        end
    endtask

    task automatic test_contention();
        int e0;
        do_reset();
        e0 = exec_cnt;
        for (int i = 0; i < NR; i++) set_fields(i, GET_CONTENTS, AW'(16'h100 + i), AW'(16'h200 + i), '0);
        req = 4'b1111;
        do_access(0, 2, 32'hA000_0000, 32'hB000_0000, 1'b1);
        do_access(1, 1, 32'hA000_0001, 32'hB000_0001, 1'b1);
        do_access(2, 3, 32'hA000_0002, 32'hB000_0002, 1'b1);
        do_access(3, 2, 32'hA000_0003, 32'hB000_0003, 1'b1);
        checks++;
        if (exec_cnt - e0 != 4 || onehot_bad != 0) begin
            errors++;
            $display("FAIL contention_pulses: exec_pulses=%0d gnt_not_onehot=%0d, expected 4 0", exec_cnt - e0, onehot_bad);
        end
    endtask

    task automatic test_lock();
        do_reset();
        set_fields(0, GET_CONTENTS, 16'h0010, 16'h0011, '0);
        set_fields(1, GET_CONTENTS, 16'h0020, 16'h0021, '0);
        req = 4'b0011;
        req_lock = 4'b0001;
        do_access(0, 1, 32'h1, 32'h2, 1'b0);
        do_access(0, 2, 32'h3, 32'h4, 1'b0);
        req_lock = 4'b0000;
        do_access(0, 1, 32'h5, 32'h6, 1'b1);
        do_access(1, 1, 32'h7, 32'h8, 1'b1);
    endtask

    task automatic test_timeout();
        do_reset();
        set_fields(2, GET_CONTENTS, 16'h0300, 16'h0301, '0);
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || mem_execute !== 1'b1) begin
            errors++;
            $display("FAIL timeout_issue: gnt=%b exec=%b, expected 0100 1", gnt, mem_execute);
        end
        mem_ready = 1'b1; read_data1 = 32'h1111_1111; read_data2 = 32'h2222_2222;
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        checks++;
        if (done !== 4'b0000 || gnt !== 4'b0100 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait8: done=%b gnt=%b err=%b, expected 0000 0100 0", done, gnt, err);
        end
        tick();
        checks++;
        if (done !== 4'b0100 || err !== 1'b1 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL timeout_done: done=%b err=%b rdata1=%h, expected 0100 1 00000000", done, err, rdata1);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (err !== 1'b0 || done !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_clear: err=%b done=%b, expected 0 0000", err, done);
        end
        set_fields(0, GET_CONTENTS, 16'h0005, 16'h0006, '0);
        req = 4'b0001;
        do_access(0, 2, 32'h5555_0000, 32'h6666_0000, 1'b1);
    endtask

    task automatic test_late_change();
        set_fields(0, SET_CONTENTS, 16'h0055, 16'h0066, 32'hCAFE_0001);
        req = 4'b0001;
        tick();
        checks++;
        if (mem_func !== SET_CONTENTS || address1 !== 16'h0055 || write_data !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL late_issue: func=%b a1=%h wd=%h, expected 10 0055 cafe0001", mem_func, address1, write_data);
        end
        set_fields(0, GET_CONTENTS, 16'h00AA, 16'h00BB, 32'h1234_0000);
        tick();
        checks++;
        if (address1 !== 16'h0055 || address2 !== 16'h0066 || write_data !== 32'hCAFE_0001 || mem_func !== 2'b00) begin
            errors++;
            $display("FAIL late_hold: a1=%h a2=%h wd=%h func=%b, expected 0055 0066 cafe0001 00",
                     address1, address2, write_data, mem_func);
        end
        tick();
        mem_ready = 1'b1; read_data1 = 32'h1234_5678; read_data2 = 32'h9ABC_DEF0;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (done !== 4'b0001 || address1 !== 16'h0055 || rdata1 !== 32'h1234_5678 || rdata2 !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL late_done: done=%b a1=%h r1=%h r2=%h, expected 0001 0055 12345678 9abcdef0",
                     done, address1, rdata1, rdata2);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_in_wait();
        set_fields(0, GET_CONTENTS, 16'h0777, 16'h0778, 32'h7777_7777);
        req = 4'b0001;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (mem_execute !== 1'b0 || gnt !== '0 || done !== '0 || err !== 1'b0 ||
            address1 !== '0 || write_data !== '0 || rdata1 !== '0) begin
            errors++;
            $display("FAIL reset_wait: exec=%b gnt=%b done=%b err=%b a1=%h wd=%h r1=%h, expected all 0",
                     mem_execute, gnt, done, err, address1, write_data, rdata1);
        end
        tick();
        checks++;
        if (done !== '0) begin
            errors++;
            $display("FAIL reset_no_done: done=%b, expected 0000", done);
        end
        rst = 1'b0;
        set_fields(1, GET_CONTENTS, 16'h0888, 16'h0889, '0);
        req = 4'b0011;
        do_access(0, 1, 32'hAAAA_0000, 32'hBBBB_0000, 1'b1);
        do_access(1, 2, 32'hAAAA_0001, 32'hBBBB_0001, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_timeout();
        test_late_change();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
